iterative_mdu: RTL and testbench

ITERATIVE_MDU -- requirements
Module: iterative_mdu

---
 rtl/imdu_pkg.sv | 22 ++
 rtl/imdu_sign_fix.sv | 13 +
 rtl/iterative_mdu.sv | 150 +++++++++++++++
 tb/tb_iterative_mdu.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/imdu_pkg.sv
// Shared types for the iterative multiply/divide unit.
// Operation encoding and FSM state.
package imdu_pkg;

    typedef enum logic [2:0] {
        READ_HI,
        READ_LO,
        WRITE_HI,
        WRITE_LO,
        START_SIGNED_MUL,
        START_UNSIGNED_MUL,
        START_SIGNED_DIV,
        START_UNSIGNED_DIV
    } mdu_operation_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX
    } mdu_state_t;

endpackage

// File: rtl/imdu_sign_fix.sv
// Conditional two's-complement negate; with negate tied to the
// sign bit it yields the absolute value.
module imdu_sign_fix #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] value,
    input  logic             negate,
    output logic [WIDTH-1:0] result
);

    assign result = negate ? (~value + WIDTH'(1)) : value;

endmodule

// File: rtl/iterative_mdu.sv
// Radix-2 iterative multiply/divide unit with HI/LO result registers.
// Optional cancel input enabled by defining IMDU_CANCEL_EN.
module iterative_mdu
    import imdu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
`ifdef IMDU_CANCEL_EN
    input  logic             cancel,
`endif
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    input  mdu_operation_t   operation,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] dataRead
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

    mdu_state_t state, state_nxt;
    logic [CW-1:0] cnt;
    logic [WIDTH-1:0] hi, lo;
    logic [WIDTH-1:0] acc, low, divr;
    logic div_q, neg_q, rem_neg_q, zero_q;
    logic abort;

`ifdef IMDU_CANCEL_EN
    assign abort = cancel;
`else
    assign abort = 1'b0;
`endif

    logic is_div_in, signed_in, start_op, accept, div0_in;
    logic neg1, neg2;
    logic [WIDTH-1:0] abs1, abs2;

    assign is_div_in = (operation == START_SIGNED_DIV)
                    || (operation == START_UNSIGNED_DIV);
    assign signed_in = (operation == START_SIGNED_MUL)
                    || (operation == START_SIGNED_DIV);
    assign start_op = is_div_in || signed_in
                   || (operation == START_UNSIGNED_MUL);
    assign accept  = (state == IDLE) && start && start_op;
    assign div0_in = is_div_in && (operand2 == '0);
    assign neg1    = signed_in && operand1[WIDTH-1];
    assign neg2    = signed_in && operand2[WIDTH-1];

    imdu_sign_fix #(.WIDTH(WIDTH)) u_abs1 (
        .value(operand1), .negate(neg1), .result(abs1)
    );
    imdu_sign_fix #(.WIDTH(WIDTH)) u_abs2 (
        .value(operand2), .negate(neg2), .result(abs2)
    );

    // One iteration of each algorithm; the +1/+2 bits hold carry/borrow.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_diff;
    logic             div_ok;

    assign mul_sum   = {1'b0, acc} + (low[0] ? {1'b0, divr} : '0);
    assign div_shift = {acc, low[WIDTH-1]};
    assign div_diff  = {1'b0, div_shift} - {2'b00, divr};
    assign div_ok    = ~div_diff[WIDTH+1];

    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    imdu_sign_fix #(.WIDTH(2*WIDTH)) u_prod (
        .value({acc, low}), .negate(neg_q), .result(prod_fix)
    );
    imdu_sign_fix #(.WIDTH(WIDTH)) u_quo (
        .value(low), .negate(neg_q), .result(quo_fix)
    );
    imdu_sign_fix #(.WIDTH(WIDTH)) u_rem (
        .value(acc), .negate(rem_neg_q), .result(rem_fix)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = div0_in ? FIX : CALC;
            CALC: if (cnt == CW'(1)) state_nxt = FIX;
            FIX:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (abort && (state != IDLE)) state_nxt = IDLE;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;
            if (accept) cnt <= div0_in ? '0 : CNT_INIT;
            else if (state == CALC) cnt <= cnt - CW'(1);
            if ((state == IDLE) && start) begin
                if (operation == WRITE_HI) hi <= operand1;
                if (operation == WRITE_LO) lo <= operand1;
            end
            if ((state == FIX) && !abort) begin
                done <= 1'b1;
                if (!zero_q) begin
                    if (div_q) {hi, lo} <= {rem_fix, quo_fix};
                    else       {hi, lo} <= prod_fix;
                end
            end
        end
    end

    // Working registers carry no reset; they are loaded on every accept.
    always_ff @(posedge clock) begin
        if (accept) begin
            acc       <= '0;
            low       <= abs1;
            divr      <= abs2;
            div_q     <= is_div_in;
            neg_q     <= neg1 ^ neg2;
            rem_neg_q <= neg1;
            zero_q    <= div0_in;
        end else if (state == CALC) begin
            if (div_q) begin
                acc <= div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                low <= {low[WIDTH-2:0], div_ok};
            end else begin
                acc <= mul_sum[WIDTH:1];
                low <= {mul_sum[0], low[WIDTH-1:1]};
            end
        end
    end

    assign busy = (state != IDLE);

    always_comb begin
        dataRead = '0;
        if (operation == READ_HI) dataRead = hi;
        if (operation == READ_LO) dataRead = lo;
    end

endmodule

// File: tb/tb_iterative_mdu.sv
// Directed bench for iterative_mdu (WIDTH=32).
// Define IMDU_CANCEL_EN to also exercise cancel.
module tb_iterative_mdu;
    import imdu_pkg::*;

    localparam int W = 32;

    logic           clock = 1'b0;
    logic           reset = 1'b0;
    logic [W-1:0]   operand1 = '0;
    logic [W-1:0]   operand2 = '0;
    mdu_operation_t operation = READ_HI;
    logic           start = 1'b0;
    logic           busy, done;
    logic [W-1:0]   dataRead;
`ifdef IMDU_CANCEL_EN
    logic           cancel = 1'b0;
`endif

    iterative_mdu #(.WIDTH(W)) dut (
        .clock(clock),
        .reset(reset),
`ifdef IMDU_CANCEL_EN
        .cancel(cancel),
`endif
        .operand1(operand1),
        .operand2(operand2),
        .operation(operation),
        .start(start),
        .busy(busy),
        .done(done),
        .dataRead(dataRead)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        mdu_operation_t op;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [W-1:0]   hi;
        logic [W-1:0]   lo;
        int             nbusy;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic read_hilo(output logic [W-1:0] h, output logic [W-1:0] l);
        operation = READ_HI;
        #1 h = dataRead;
        operation = READ_LO;
        #1 l = dataRead;
        operation = READ_HI;
    endtask

    task automatic write_reg(input mdu_operation_t op, input logic [W-1:0] v);
        @(negedge clock);
        operation = op;
        operand1  = v;
        start     = 1'b1;
        @(negedge clock);
        start     = 1'b0;
        operation = READ_HI;
    endtask

    // Returns at the negedge of cycle 1; operands are scrambled after accept.
    task automatic launch(input mdu_operation_t op, input logic [W-1:0] a,
                          input logic [W-1:0] b);
        @(negedge clock);
        operation = op;
        operand1  = a;
        operand2  = b;
        start     = 1'b1;
        @(negedge clock);
        start     = 1'b0;
        operation = READ_HI;
        operand1  = ~a;
        operand2  = ~b;
    endtask

    task automatic observe(input int ncyc, output int bc, output int dc);
        bc = 0;
        dc = 0;
        for (int i = 0; i < ncyc; i++) begin
            if (busy) bc++;
            if (done) dc++;
            @(negedge clock);
        end
    endtask

    initial begin
        logic [W-1:0] h, l;
        int bc, dc;

        vecs[0] = '{START_UNSIGNED_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF,
                    32'hFFFFFFFE, 32'h00000001, 33};
        vecs[1] = '{START_SIGNED_MUL, 32'hFFFFFFFD, 32'h00000007,
                    32'hFFFFFFFF, 32'hFFFFFFEB, 33};
        vecs[2] = '{START_SIGNED_DIV, 32'hFFFFFFF9, 32'h00000002,
                    32'hFFFFFFFF, 32'hFFFFFFFD, 33};
        vecs[3] = '{START_SIGNED_DIV, 32'h80000000, 32'hFFFFFFFF,
                    32'h00000000, 32'h80000000, 33};
        vecs[4] = '{START_UNSIGNED_DIV, 32'd100, 32'd7,
                    32'd2, 32'd14, 33};
        vecs[5] = '{START_UNSIGNED_MUL, 32'h12345678, 32'h10,
                    32'h00000001, 32'h23456780, 33};
        vecs[6] = '{START_SIGNED_DIV, 32'd7, 32'hFFFFFFFE,
                    32'h00000001, 32'hFFFFFFFD, 33};
        vecs[7] = '{START_SIGNED_MUL, 32'h80000000, 32'h80000000,
                    32'h40000000, 32'h00000000, 33};
        vecs[8] = '{START_UNSIGNED_DIV, 32'hFFFFFFFF, 32'd1,
                    32'h00000000, 32'hFFFFFFFF, 33};

        repeat (2) @(negedge clock);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        read_hilo(h, l);
        check("reset_hi", h, 32'd0);
        check("reset_lo", l, 32'd0);
        reset = 1'b1;

        for (int i = 0; i < 9; i++) begin
            launch(vecs[i].op, vecs[i].a, vecs[i].b);
            observe(W + 5, bc, dc);
            check($sformatf("v%0d_busy", i), 32'(bc), 32'(vecs[i].nbusy));
            check($sformatf("v%0d_done", i), 32'(dc), 32'd1);
            read_hilo(h, l);
            check($sformatf("v%0d_hi", i), h, vecs[i].hi);
            check($sformatf("v%0d_lo", i), l, vecs[i].lo);
        end

        // divide by zero keeps HI/LO
        write_reg(WRITE_HI, 32'h11);
        write_reg(WRITE_LO, 32'h22);
        launch(START_UNSIGNED_DIV, 32'd5, 32'd0);
        observe(6, bc, dc);
        check("div0_busy", 32'(bc), 32'd1);
        check("div0_done", 32'(dc), 32'd1);
        read_hilo(h, l);
        check("div0_hi", h, 32'h11);
        check("div0_lo", l, 32'h22);

        // start and WRITE_HI while busy are ignored
        launch(START_SIGNED_DIV, 32'h80000000, 32'hFFFFFFFF);
        repeat (3) @(negedge clock);
        operation = WRITE_HI;
        operand1  = 32'hDEAD;
        start     = 1'b1;
        @(negedge clock);
        operation = START_UNSIGNED_MUL;
        operand1  = 32'd3;
        operand2  = 32'd3;
        @(negedge clock);
        start     = 1'b0;
        operation = READ_HI;
        observe(W + 5, bc, dc);
        check("midop_done", 32'(dc), 32'd1);
        read_hilo(h, l);
        check("midop_hi", h, 32'h0);
        check("midop_lo", l, 32'h80000000);
        observe(W, bc, dc);
        check("midop_nobusy", 32'(bc), 32'd0);

        // asynchronous reset in CALC cycle 10
        write_reg(WRITE_HI, 32'hAA);
        write_reg(WRITE_LO, 32'hBB);
        launch(START_UNSIGNED_MUL, 32'd3, 32'd5);
        repeat (9) @(negedge clock);
        reset = 1'b0;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        read_hilo(h, l);
        check("rst_hi", h, 32'h0);
        check("rst_lo", l, 32'h0);
        @(negedge clock);
        reset = 1'b1;
        observe(W + 5, bc, dc);
        check("rst_nodone", 32'(dc), 32'd0);
        check("rst_idle", 32'(bc), 32'd0);
        launch(START_SIGNED_MUL, 32'hFFFFFFFD, 32'd7);
        observe(W + 5, bc, dc);
        check("post_rst_done", 32'(dc), 32'd1);
        read_hilo(h, l);
        check("post_rst_hi", h, 32'hFFFFFFFF);
        check("post_rst_lo", l, 32'hFFFFFFEB);

`ifdef IMDU_CANCEL_EN
        write_reg(WRITE_HI, 32'h7);
        write_reg(WRITE_LO, 32'h7);
        launch(START_UNSIGNED_DIV, 32'd100, 32'd3);
        repeat (4) @(negedge clock);
        cancel = 1'b1;
        @(negedge clock);
        cancel = 1'b0;
        check("cancel_busy", 32'(busy), 32'd0);
        observe(W + 5, bc, dc);
        check("cancel_nodone", 32'(dc), 32'd0);
        read_hilo(h, l);
        check("cancel_hi", h, 32'h7);
        check("cancel_lo", l, 32'h7);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
